// File: rtl/dma_priority_arbiter_if.sv
// Handshake/bus bundle between the DMA channel-request logic, the CPU hold
// interface and the arbiter; master drives requests/config, slave is the arbiter.
interface dma_priority_arbiter_if #(parameter int NCH = 4);
  logic [NCH-1:0] DREQ;
  logic           HLDA;
  logic [NCH-1:0] maskReg;
  logic [NCH-1:0] requestReg;
  logic [7:0]     commandReg;
  logic           serviceDone;
  logic           HRQ;
  logic [NCH-1:0] DACK;
  logic [NCH-1:0] validDREQ;
  logic [1:0]     activeCh;
  logic           chActive;

  modport master (
    output DREQ, HLDA, maskReg, requestReg, commandReg, serviceDone,
    input  HRQ, DACK, validDREQ, activeCh, chActive
  );
  modport slave (
    input  DREQ, HLDA, maskReg, requestReg, commandReg, serviceDone,
    output HRQ, DACK, validDREQ, activeCh, chActive
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 4-channel DMA request arbiter: qualifies DREQs, picks a winner by fixed or
// rotating priority, and runs the HRQ/HLDA/DACK hold handshake with the CPU.
module dma_arb_chan (
  input  logic dreq_s,
  input  logic dreq_lo,
  input  logic mask,
  input  logic sw_req,
  input  logic grant,
  input  logic dack_hi,
  output logic valid,
  output logic dack
);
  // Software requests deliberately bypass the mask.
  assign valid = ((dreq_s ^ dreq_lo) & ~mask) | sw_req;
  assign dack  = dack_hi ? grant : ~grant;
endmodule

module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input logic                  CLK,
  input logic                  RESET_N,
  dma_priority_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] dreq_s;
  logic [NCH-1:0] grant_q, grant_nxt;
  logic [1:0]     act_q, act_nxt;
  logic [1:0]     last_q, last_nxt;
  logic [NCH-1:0] valid;
  logic [1:0]     win, start, idx;
  logic           found;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      dma_arb_chan u_ch (
        .dreq_s (dreq_s[g]),
        .dreq_lo(bus.commandReg[6]),
        .mask   (bus.maskReg[g]),
        .sw_req (bus.requestReg[g]),
        .grant  (grant_q[g]),
        .dack_hi(bus.commandReg[7]),
        .valid  (valid[g]),
        .dack   (bus.DACK[g])
      );
    end
  endgenerate

  // Fixed priority is the rotating search anchored at channel 0.
  always_comb begin
    start = bus.commandReg[4] ? last_q + 2'd1 : 2'd0;
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NCH; k++) begin
      idx = start + k[1:0];
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      dreq_s  <= '0;
      grant_q <= '0;
      act_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state   <= state_nxt;
      dreq_s  <= bus.DREQ;
      grant_q <= grant_nxt;
      act_q   <= act_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    act_nxt   = act_q;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (!bus.commandReg[2] && found) begin
          act_nxt   = win;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.HLDA) begin
          grant_nxt         = '0;
          grant_nxt[act_q]  = 1'b1;
          state_nxt         = GRANT;
        end else if (!found || bus.commandReg[2]) begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        // Controller disable is ignored here: a live grant always runs out.
        if (bus.serviceDone) begin
          last_nxt  = act_q;
          grant_nxt = '0;
          state_nxt = bus.HLDA ? RELEASE : IDLE;
        end else if (!bus.HLDA) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      RELEASE: begin
        if (!bus.HLDA) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.HRQ       = (state == REQ) || (state == GRANT);
  assign bus.chActive  = (state == GRANT);
  assign bus.activeCh  = act_q;
  assign bus.validDREQ = valid;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: expected grants go to a scoreboard
// queue and a monitor checks each new grant; other checks are inline.
module tb_dma_priority_arbiter;
  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] dack;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic prev_act = 1'b0;

  dma_priority_arbiter_if #(.NCH(4)) bus ();
  dma_priority_arbiter #(.NCH(4)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [3:0] dack);
    exp_t e;
    e.ch = ch;
    e.dack = dack;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [7:0] cmd);
    RESET_N = 1'b0;
    bus.DREQ = 4'b0000;
    bus.HLDA = 1'b0;
    bus.maskReg = 4'b0000;
    bus.requestReg = 4'b0000;
    bus.serviceDone = 1'b0;
    bus.commandReg = cmd;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic wait_hrq();
    for (int i = 0; i < 10; i++) begin
      if (bus.HRQ) break;
      tick();
    end
    chk("hrq_wait", {7'd0, bus.HRQ}, 8'd1);
  endtask

  // Full grant cycle: request, hold ack, service done, hold release.
  task automatic serve(input logic [1:0] ch, input logic [3:0] dack);
    wait_hrq();
    push(ch, dack);
    bus.HLDA = 1'b1;
    tick();
    bus.serviceDone = 1'b1;
    tick();
    bus.serviceDone = 1'b0;
    bus.HLDA = 1'b0;
    tick();
  endtask

  // Monitor: every rising chActive must match the oldest expected grant.
  always @(negedge CLK) begin
    if (RESET_N && bus.chActive && !prev_act) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("grant_ch", {6'd0, bus.activeCh}, {6'd0, e.ch});
        chk("grant_dack", {4'd0, bus.DACK}, {4'd0, e.dack});
      end
    end
    prev_act = bus.chActive;
  end

  initial begin
    // Reset state
    do_reset(8'h00);
    RESET_N = 1'b0;
    #1;
    chk("rst_hrq", {7'd0, bus.HRQ}, 8'd0);
    chk("rst_chactive", {7'd0, bus.chActive}, 8'd0);
    chk("rst_activech", {6'd0, bus.activeCh}, 8'd0);
    chk("rst_dack", {4'd0, bus.DACK}, 8'h0F);
    RESET_N = 1'b1;

    // Fixed priority, latency
    do_reset(8'h00);
    bus.DREQ = 4'b0110;
    tick();
    chk("lat_hrq_c1", {7'd0, bus.HRQ}, 8'd0);
    chk("fix_valid", {4'd0, bus.validDREQ}, 8'h06);
    tick();
    chk("lat_hrq_c2", {7'd0, bus.HRQ}, 8'd1);
    push(2'd1, 4'b1101);
    bus.HLDA = 1'b1;
    tick();
    chk("fix_chactive", {7'd0, bus.chActive}, 8'd1);
    bus.serviceDone = 1'b1;
    tick();
    bus.serviceDone = 1'b0;
    chk("rel_hrq", {7'd0, bus.HRQ}, 8'd0);
    chk("rel_chactive", {7'd0, bus.chActive}, 8'd0);
    chk("rel_dack", {4'd0, bus.DACK}, 8'h0F);
    tick();
    chk("rel_hold", {7'd0, bus.HRQ}, 8'd0);

    // Rotating priority
    do_reset(8'h10);
    bus.DREQ = 4'b1111;
    serve(2'd0, 4'b1110);
    serve(2'd1, 4'b1101);
    serve(2'd2, 4'b1011);
    serve(2'd3, 4'b0111);
    serve(2'd0, 4'b1110);

    // Mask vs software request
    do_reset(8'h00);
    bus.maskReg = 4'b1111;
    bus.DREQ = 4'b1111;
    bus.requestReg = 4'b0100;
    tick();
    chk("mask_valid", {4'd0, bus.validDREQ}, 8'h04);
    serve(2'd2, 4'b1011);

    // Polarity
    do_reset(8'hC0);
    bus.DREQ = 4'b1110;
    tick();
    chk("pol_valid", {4'd0, bus.validDREQ}, 8'h01);
    serve(2'd0, 4'b0001);

    // Preemption keeps lastSvc (rotating start stays at channel 0)
    do_reset(8'h10);
    bus.DREQ = 4'b0100;
    wait_hrq();
    push(2'd2, 4'b1011);
    bus.HLDA = 1'b1;
    tick();
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1111;
    tick();
    chk("pre_chactive", {7'd0, bus.chActive}, 8'd0);
    chk("pre_hrq", {7'd0, bus.HRQ}, 8'd0);
    chk("pre_dack", {4'd0, bus.DACK}, 8'h0F);
    serve(2'd0, 4'b1110);

    // Disable during REQ aborts; during GRANT does not
    do_reset(8'h00);
    bus.DREQ = 4'b0001;
    wait_hrq();
    bus.commandReg = 8'h04;
    tick();
    chk("dis_req_hrq", {7'd0, bus.HRQ}, 8'd0);
    tick();
    tick();
    chk("dis_idle_hrq", {7'd0, bus.HRQ}, 8'd0);
    bus.commandReg = 8'h00;
    wait_hrq();
    push(2'd0, 4'b1110);
    bus.HLDA = 1'b1;
    tick();
    bus.commandReg = 8'h04;
    tick();
    chk("dis_grant_act", {7'd0, bus.chActive}, 8'd1);
    chk("dis_grant_dack", {4'd0, bus.DACK}, 8'h0E);
    bus.serviceDone = 1'b1;
    tick();
    bus.serviceDone = 1'b0;
    chk("dis_rel_dack", {4'd0, bus.DACK}, 8'h0F);
    bus.HLDA = 1'b0;
    tick();

    // Async reset mid-GRANT
    do_reset(8'h00);
    bus.DREQ = 4'b1000;
    wait_hrq();
    push(2'd3, 4'b0111);
    bus.HLDA = 1'b1;
    tick();
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("arst_hrq", {7'd0, bus.HRQ}, 8'd0);
    chk("arst_chactive", {7'd0, bus.chActive}, 8'd0);
    chk("arst_dack", {4'd0, bus.DACK}, 8'h0F);
    tick();
    RESET_N = 1'b1;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b0000;
    tick();
    tick();

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter NCH, 4, channel count; the block SHALL support only NCH=4.
REQ-002 Port CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port RESET_N  in  1  reset, asynchronous and active-low: assertion clears all state immediately; release is sampled on CLK.
REQ-004 Port DREQ  in  4  raw channel DMA requests; polarity set by commandReg[6].
REQ-005 Port HLDA  in  1  hold acknowledge from the CPU.
REQ-006 Port maskReg  in  4  per-channel mask; 1 = hardware request ignored.
REQ-007 Port requestReg  in  4  per-channel software request bits, already decoded.
REQ-008 Port commandReg  in  8  control bits: [2] controller disable, [4] rotating priority, [6] DREQ active-low, [7] DACK active-high.
REQ-009 Port serviceDone  in  1  one-cycle pulse from timing control marking the end of service for activeCh.
REQ-010 Port HRQ  out  1  hold request to the CPU.
REQ-011 Port DACK  out  4  channel acknowledges; polarity set by commandReg[7].
REQ-012 Port validDREQ  out  4  qualified pending requests; feeds status register bits [7:4].
REQ-013 Port activeCh  out  2  granted channel number.
REQ-014 Port chActive  out  1  1 while a grant is live; enables the register/timing stages.

Function
REQ-015 DREQ SHALL be registered once into dreqS; each bit is active when dreqS[i] XOR commandReg[6] = 1.
REQ-016 validDREQ[i] SHALL equal (active dreqS[i] AND NOT maskReg[i]) OR requestReg[i]; software requests bypass the mask.
REQ-017 The FSM SHALL have four states: IDLE, REQ, GRANT, RELEASE; the reset state is IDLE.
REQ-018 In IDLE, if commandReg[2]=0 and validDREQ is non-zero, the block SHALL latch the winning channel into activeCh and enter REQ on the next edge.
REQ-019 In IDLE with commandReg[2]=1, the block SHALL stay in IDLE regardless of requests.
REQ-020 Fixed priority (commandReg[4]=0): channel 0 highest, then 1, 2, 3.
REQ-021 Rotating priority (commandReg[4]=1): the channel after lastSvc (mod 4) is highest, continuing upward with wrap; lastSvc resets to 3.
REQ-022 In REQ: HRQ=1 and activeCh is frozen; HLDA=1 moves to GRANT.
REQ-023 In REQ: if validDREQ becomes 0 or commandReg[2] becomes 1 before HLDA, the block SHALL return to IDLE and drop HRQ.
REQ-024 In GRANT: HRQ=1, chActive=1, internal grant vector is one-hot at activeCh, and activeCh is frozen.
REQ-025 DACK SHALL equal commandReg[7] ? grant : ~grant, applied combinationally to the registered grant vector.
REQ-026 In GRANT, serviceDone=1 SHALL set lastSvc=activeCh, clear grant, and go to RELEASE if HLDA=1, else to IDLE.
REQ-027 In GRANT, HLDA=0 without serviceDone SHALL clear grant and go to IDLE with lastSvc unchanged (preemption).
REQ-028 Setting commandReg[2]=1 during GRANT SHALL NOT abort the grant.
REQ-029 In RELEASE: HRQ=0, chActive=0, all DACK inactive; the block waits for HLDA=0, then enters IDLE.
REQ-030 Minimum latency SHALL be: DREQ edge -> HRQ in 2 cycles; HLDA -> DACK/chActive in 1 cycle.

Reset
REQ-031 While RESET_N=0: state=IDLE, HRQ=0, chActive=0, activeCh=0, grant=0, lastSvc=3, dreqS=0 (so DACK shows its inactive value).
REQ-032 Reset asserted mid-GRANT SHALL immediately deassert HRQ, chActive and DACK.

Verification
REQ-033 Fixed priority: cmd=0x00, DREQ=0110 -> HRQ at cycle 2; HLDA=1 -> activeCh=1, DACK=1101.
REQ-034 Rotating priority: cmd=0x10, all DREQ held, serviceDone after each grant -> grant order 0, 1, 2, 3, 0.
REQ-035 Mask vs software request: maskReg=1111, DREQ=1111, requestReg=0100 -> validDREQ=0100, activeCh=2.
REQ-036 Polarity: cmd=0xC0, DREQ=1110 -> channel 0 granted, DACK=0001.
REQ-037 Preemption and disable: HLDA drops in GRANT -> IDLE with lastSvc kept; cmd[2]=1 in REQ -> HRQ=0 next cycle.
REQ-038 Async reset: RESET_N pulsed low mid-GRANT, between clock edges -> HRQ=0 and DACK inactive immediately, without waiting for CLK.
